// File: rtl/morse_tx_scheduler_pkg.sv
// Shared types and constants for the Morse terminal UART scheduler.
//   tx_state_e : scheduler FSM states
//   ASCII_CR/LF: line-ending bytes emitted between lines
package morse_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHAR = 2'd1,
    CR   = 2'd2,
    LF   = 2'd3
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/morse_tx_scheduler_if.sv
// Bundle between the decoder/ROM stage, the scheduler and the UART write port.
//   char_valid/char_data : decoded character strobe and byte
//   nl_req               : newline request strobe
//   clr_ovf              : clear the sticky overflow flag
//   tx_full              : UART transmit FIFO full (backpressure)
//   wr_uart/w_data       : UART write strobe and byte
//   busy/overflow/col    : scheduler status
// Modport slave is the scheduler; master is the surrounding environment.
interface morse_tx_scheduler_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       nl_req;
  logic       clr_ovf;
  logic       tx_full;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       busy;
  logic       overflow;
  logic [7:0] col;

  modport slave (
    input  char_valid, char_data, nl_req, clr_ovf, tx_full,
    output wr_uart, w_data, busy, overflow, col
  );

  modport master (
    output char_valid, char_data, nl_req, clr_ovf, tx_full,
    input  wr_uart, w_data, busy, overflow, col
  );
endinterface

// File: rtl/morse_tx_scheduler_queue.sv
// Show-ahead synchronous character FIFO, DEPTH x 8.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and byte (ignored when full unless popping)
//   pop        : remove head (ignored when empty)
//   dout       : current head byte
//   empty/full : occupancy flags; count: entries held (0..DEPTH)
module tx_char_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a full queue still accepts.
  assign do_push = push && (!full || do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/morse_tx_scheduler.sv
// Arbitrates the shared UART write port between queued decoded characters
// and CR/LF line endings (on request and automatic at LINE_LEN columns).
//   clk, reset : clock, synchronous active-high reset
//   bus        : scheduler side of morse_tx_scheduler_if (see interface)
module morse_tx_scheduler
  import morse_tx_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LINE_LEN = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  morse_tx_scheduler_if.slave  bus
);
  localparam logic [7:0] LINE_END = 8'(LINE_LEN);

  tx_state_e              state;
  logic [7:0]             w_data_q;
  logic [7:0]             col_q;
  logic                   nl_pending;
  logic                   overflow_q;

  logic [7:0]             q_head;
  logic                   q_empty;
  logic                   q_full;
  logic [$clog2(DEPTH):0] q_count;

  logic                   q_pop;
  logic                   drop;
  logic                   lf_write;
  logic [7:0]             col_inc;
  logic                   wrap;

  assign q_pop    = (state == CHAR) && !bus.tx_full;
  assign drop     = bus.char_valid && q_full && !q_pop;
  assign lf_write = (state == LF) && !bus.tx_full;
  assign col_inc  = col_q + 8'd1;
  assign wrap     = (col_inc == LINE_END);

  tx_char_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (bus.char_valid),
    .pop   (q_pop),
    .din   (bus.char_data),
    .dout  (q_head),
    .empty (q_empty),
    .full  (q_full),
    .count (q_count)
  );

  // w_data is registered on state entry; the queue head cannot change while
  // in CHAR because the only pop is the one that leaves CHAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      w_data_q <= 8'h00;
      col_q    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (nl_pending) begin
            state    <= CR;
            w_data_q <= ASCII_CR;
          end else if (!q_empty) begin
            state    <= CHAR;
            w_data_q <= q_head;
          end
        end
        CHAR: begin
          if (!bus.tx_full) begin
            // Column wraps to 0 on the write that completes the line, so col
            // never reports LINE_LEN; the auto CR/LF goes out immediately.
            col_q <= wrap ? 8'd0 : col_inc;
            if (wrap) begin
              state    <= CR;
              w_data_q <= ASCII_CR;
            end else begin
              state    <= IDLE;
              w_data_q <= 8'h00;
            end
          end
        end
        CR: begin
          if (!bus.tx_full) begin
            state    <= LF;
            w_data_q <= ASCII_LF;
          end
        end
        LF: begin
          if (!bus.tx_full) begin
            state    <= IDLE;
            w_data_q <= 8'h00;
            col_q    <= 8'd0;
          end
        end
        default: begin
          state    <= IDLE;
          w_data_q <= 8'h00;
        end
      endcase
    end
  end

  // A request coinciding with the LF write survives, yielding a second CR/LF.
  always_ff @(posedge clk) begin
    if (reset)            nl_pending <= 1'b0;
    else if (bus.nl_req)  nl_pending <= 1'b1;
    else if (lf_write)    nl_pending <= 1'b0;
  end

  // A drop in the same cycle as the clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset)            overflow_q <= 1'b0;
    else if (drop)        overflow_q <= 1'b1;
    else if (bus.clr_ovf) overflow_q <= 1'b0;
  end

  assign bus.wr_uart  = (state != IDLE) && !bus.tx_full;
  assign bus.w_data   = w_data_q;
  assign bus.col      = col_q;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state != IDLE) || (q_count != '0) || nl_pending;
endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Self-checking bench for morse_tx_scheduler (DEPTH=4, LINE_LEN=4).
// A job-list reference model predicts each cycle's UART byte into a
// scoreboard queue; a negedge monitor pops and compares on every wr_uart.
module tb_morse_tx_scheduler;
  localparam int DEPTH    = 4;
  localparam int LINE_LEN = 4;
  localparam logic [7:0] B_CR = 8'h0D;
  localparam logic [7:0] B_LF = 8'h0A;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  morse_tx_scheduler_if bus();

  morse_tx_scheduler #(.DEPTH(DEPTH), .LINE_LEN(LINE_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: characters waiting, the output job being emitted (bytes
  // still to write; empty means a decision cycle), and line bookkeeping.
  logic [7:0] mq[$];
  logic [7:0] job[$];
  logic [7:0] exp_q[$];
  bit         held;   // job is a queued character still occupying a slot
  bit         m_nl;
  bit         m_ovf;
  int         m_col;

  function automatic bit model_busy();
    return (job.size() != 0) || (mq.size() != 0) || m_nl;
  endfunction

  task automatic model_clear();
    mq.delete();
    job.delete();
    held  = 0;
    m_nl  = 0;
    m_ovf = 0;
    m_col = 0;
  endtask

  task automatic model_step(input bit rst, input bit cv, input logic [7:0] cd,
                            input bit nr, input bit co, input bit tf);
    bit was_idle = (job.size() == 0);
    int total    = mq.size() + int'(held);
    bit nl0      = m_nl;
    bit popped   = 0;
    bit lf_done  = 0;
    bit dropped;
    logic [7:0] b;
    if (!was_idle && !tf) begin
      b = job.pop_front();
      exp_q.push_back(b);
      if (held) begin
        popped = 1;
        held   = 0;
        m_col++;
        if (m_col == LINE_LEN) begin
          m_col = 0;
          job.push_back(B_CR);
          job.push_back(B_LF);
        end
      end else if (b == B_LF) begin
        m_col   = 0;
        lf_done = 1;
      end
    end
    if (rst) begin
      model_clear();
      return;
    end
    if (was_idle) begin
      if (nl0) begin
        job.push_back(B_CR);
        job.push_back(B_LF);
      end else if (mq.size() != 0) begin
        job.push_back(mq.pop_front());
        held = 1;
      end
    end
    dropped = cv && !(total < DEPTH || popped);
    if (cv && !dropped) mq.push_back(cd);
    if (dropped)        m_ovf = 1;
    else if (co)        m_ovf = 0;
    if (nr)             m_nl = 1;
    else if (lf_done)   m_nl = 0;
  endtask

  task automatic compare_state();
    check("col", bus.col, m_col);
    check("overflow", bus.overflow, m_ovf);
    check("busy", bus.busy, model_busy());
    if (job.size() == 0) begin
      check("w_data_idle", bus.w_data, 8'h00);
      check("wr_uart_idle", bus.wr_uart, 1'b0);
    end else begin
      check("w_data", bus.w_data, job[0]);
    end
  endtask

  // One clock: check registered state, drive this cycle's inputs, predict.
  task automatic cycle(input bit rst, input bit cv, input logic [7:0] cd,
                       input bit nr, input bit co, input bit tf);
    compare_state();
    reset          = rst;
    bus.char_valid = cv;
    bus.char_data  = cd;
    bus.nl_req     = nr;
    bus.clr_ovf    = co;
    bus.tx_full    = tf;
    model_step(rst, cv, cd, nr, co, tf);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 8'h00, 0, 0, 0);
  endtask

  task automatic push(input logic [7:0] c, input bit tf);
    cycle(0, 1, c, 0, 0, tf);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (model_busy() || bus.busy); k++) idle(1);
    check("drain_busy", bus.busy, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  // Scoreboard monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (bus.wr_uart === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", bus.wr_uart, 1'b0);
      else                   check("uart_byte", bus.w_data, exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.char_valid = 1'b0;
    bus.char_data  = 8'h00;
    bus.nl_req     = 1'b0;
    bus.clr_ovf    = 1'b0;
    bus.tx_full    = 1'b0;
    model_clear();
    @(posedge clk);
    #1;

    // Single character: one write of 0x41, col 1, busy drops.
    push(8'h41, 0);
    idle(4);
    check("s1_col", bus.col, 8'd1);
    check("s1_busy", bus.busy, 1'b0);
    drain();

    // Finish the line, then a full line "ABCD" with automatic wrap.
    cycle(0, 0, 8'h00, 1, 0, 0);
    drain();
    push("A", 0); push("B", 0); push("C", 0); push("D", 0);
    drain();
    check("s2_col", bus.col, 8'd0);

    // Overflow under backpressure; fifth character dropped.
    for (int i = 0; i < 5; i++) push(8'h61 + 8'(i), 1);
    check("s3_overflow_set", bus.overflow, 1'b1);
    drain();
    cycle(0, 0, 8'h00, 0, 1, 0);
    check("s3_overflow_clr", bus.overflow, 1'b0);

    // Newline requested while X is being written: X CR LF Y.
    push("X", 0);
    push("Y", 0);
    cycle(0, 0, 8'h00, 1, 0, 0);
    drain();

    // Request coinciding with the LF write: two CR/LF pairs.
    cycle(0, 0, 8'h00, 1, 0, 0);
    idle(2);
    cycle(0, 0, 8'h00, 1, 0, 0);
    drain();

    // Reset while parked in CR under backpressure.
    push("Z", 0);
    idle(3);
    cycle(0, 0, 8'h00, 1, 0, 0);
    cycle(0, 0, 8'h00, 0, 0, 1);
    cycle(0, 0, 8'h00, 0, 0, 1);
    check("s6_pre_col", bus.col, 8'd1);
    cycle(1, 0, 8'h00, 0, 0, 1);
    check("s6_wr_uart", bus.wr_uart, 1'b0);
    check("s6_w_data", bus.w_data, 8'h00);
    check("s6_busy", bus.busy, 1'b0);
    check("s6_col", bus.col, 8'd0);
    push("Q", 0);
    idle(4);
    check("s6_after_col", bus.col, 8'd1);
    drain();

    // Randomized traffic with bursts of backpressure.
    for (int i = 0; i < 1500; i++) begin
      automatic int pf = ((i % 200) < 40) ? 85 : 20;
      cycle(0,
            $urandom_range(0, 99) < 40,
            8'($urandom_range(32, 126)),
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < 5,
            $urandom_range(0, 99) < pf);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
